input_buffer_ctrl: RTL and testbench

//  Sequencer for the dual-port input buffer RAM. Accepts a host write stream (valid/ready) into
//  the RAM as a circular queue, then plays a tile of tile_len words to the compute array

---
 rtl/ibuf_pkg.sv | 21 ++
 rtl/ibuf_rd_addr_gen.sv | 76 +++++++
 rtl/input_buffer_ctrl.sv | 138 +++++++++++++
 tb/tb_input_buffer_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// Shared types and defaults for the input buffer sequencer.
// DATA_WIDTH/ADDR_WIDTH are the project-wide RAM dimensions.
package ibuf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 10;
  localparam int REP_WIDTH  = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    STREAM    = 2'd2,
    RELEASE   = 2'd3
  } ibuf_state_e;

  // Level and tile length must represent 0..DEPTH inclusive.
  function automatic int lvl_w(input int addr_w);
    return addr_w + 1;
  endfunction

endpackage

// File: rtl/ibuf_rd_addr_gen.sv
// Read-side counters for tile replay: base/idx/pass tracking, read issue,
// last-word detection and the one-cycle aligned m_valid/m_last flags.
module ibuf_rd_addr_gen
  import ibuf_pkg::*;
#(
  parameter  int ADDR_W = ADDR_WIDTH,
  parameter  int REP_W  = REP_WIDTH,
  localparam int LW     = lvl_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              stream_i,
  input  logic              m_ready_i,
  input  logic              release_i,
  input  logic [LW-1:0]     len_i,
  input  logic [REP_W-1:0]  rep_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              last_issue_o,
  output logic              m_valid_o,
  output logic              m_last_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [LW-1:0]     idx_q, idx_d;
  logic [REP_W-1:0]  pass_q, pass_d;
  logic              m_valid_q, m_last_q;
  logic              idx_wrap;

  always_comb begin
    rd_en_o      = stream_i & m_ready_i;
    rd_addr_o    = base_q + idx_q[ADDR_W-1:0];
    idx_wrap     = (idx_q == len_i - LW'(1));
    last_issue_o = rd_en_o & idx_wrap & (pass_q == rep_i - REP_W'(1));

    idx_d  = idx_q;
    pass_d = pass_q;
    base_d = base_q;
    if (clear_i) begin
      idx_d  = '0;
      pass_d = '0;
    end else if (rd_en_o) begin
      if (idx_wrap) begin
        idx_d  = '0;
        pass_d = pass_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    // A full-depth tile advances base by DEPTH, i.e. leaves it unchanged.
    if (release_i) begin
      base_d = base_q + len_i[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q    <= '0;
      idx_q     <= '0;
      pass_q    <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      base_q    <= base_d;
      idx_q     <= idx_d;
      pass_q    <= pass_d;
      m_valid_q <= rd_en_o;
      m_last_q  <= last_issue_o;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_last_o  = m_last_q;

endmodule

// File: rtl/input_buffer_ctrl.sv
// Input buffer sequencer: host words fill the RAM as a circular queue, and each
// requested tile is replayed repeat_cnt times to the PE array before being freed.
module input_buffer_ctrl
  import ibuf_pkg::*;
#(
  parameter  int DATA_W = DATA_WIDTH,
  parameter  int ADDR_W = ADDR_WIDTH,
  parameter  int REP_W  = REP_WIDTH,
  localparam int LW     = lvl_w(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              start,
  input  logic [LW-1:0]     tile_len,
  input  logic [REP_W-1:0]  repeat_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [LW-1:0]     level,
  output logic              buf_wr_en,
  output logic [ADDR_W-1:0] buf_wr_addr,
  output logic [DATA_W-1:0] buf_wr_data,
  output logic              buf_rd_en,
  output logic [ADDR_W-1:0] buf_rd_addr,
  input  logic [DATA_W-1:0] buf_rd_data
);

  localparam logic [LW-1:0] DEPTH_L = {1'b1, {ADDR_W{1'b0}}};

  ibuf_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [LW-1:0]     len_q, len_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              err_q, err_d;
  logic              load;
  logic              accept;
  logic              rel;
  logic              last_issue;

  // Write side runs regardless of the FSM; only free slots are ever written.
  always_comb begin
    s_ready  = (level_q < DEPTH_L);
    accept   = s_valid & s_ready;
    rel      = (state_q == RELEASE);
    wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    level_d  = level_q + LW'(accept) - (rel ? len_q : '0);
  end

  // A zero-length tile goes straight to RELEASE so done still pulses once.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    err_d   = 1'b0;
    len_d   = len_q;
    rep_d   = rep_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (tile_len > DEPTH_L) begin
            err_d = 1'b1;
          end else begin
            load    = 1'b1;
            len_d   = tile_len;
            rep_d   = (repeat_cnt == '0) ? REP_W'(1) : repeat_cnt;
            state_d = (tile_len == '0) ? RELEASE : WAIT_FILL;
          end
        end
      end
      WAIT_FILL: begin
        if (level_q >= len_q) state_d = STREAM;
      end
      STREAM: begin
        if (last_issue) state_d = RELEASE;
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      level_q  <= '0;
      len_q    <= '0;
      rep_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      len_q    <= len_d;
      rep_q    <= rep_d;
      err_q    <= err_d;
    end
  end

  ibuf_rd_addr_gen #(
    .ADDR_W (ADDR_W),
    .REP_W  (REP_W)
  ) u_rd_addr_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (load),
    .stream_i     (state_q == STREAM),
    .m_ready_i    (m_ready),
    .release_i    (rel),
    .len_i        (len_q),
    .rep_i        (rep_q),
    .rd_en_o      (buf_rd_en),
    .rd_addr_o    (buf_rd_addr),
    .last_issue_o (last_issue),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last)
  );

  assign busy        = (state_q != IDLE);
  assign done        = rel;
  assign err         = err_q;
  assign level       = level_q;
  assign m_data      = buf_rd_data;
  assign buf_wr_en   = accept;
  assign buf_wr_addr = wr_ptr_q;
  assign buf_wr_data = s_data;

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// Directed + randomized bench for input_buffer_ctrl with a 16-deep RAM model and
// a queue-based reference of held words and expected replay stream.
module tb_input_buffer_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int RW    = 4;
  localparam int LW    = AW + 1;
  localparam int DEPTH = 16;

  logic          clk, rst_n;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_data;
  logic          start;
  logic [LW-1:0] tile_len;
  logic [RW-1:0] repeat_cnt;
  logic          busy, done, err;
  logic          m_ready, m_valid, m_last;
  logic [DW-1:0] m_data;
  logic [LW-1:0] level;
  logic          buf_wr_en, buf_rd_en;
  logic [AW-1:0] buf_wr_addr, buf_rd_addr;
  logic [DW-1:0] buf_wr_data, buf_rd_data;

  input_buffer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .REP_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .start(start), .tile_len(tile_len), .repeat_cnt(repeat_cnt),
    .busy(busy), .done(done), .err(err),
    .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data), .m_last(m_last),
    .level(level),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
    if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
  end

  // Reference model
  logic [DW-1:0] held[$];
  logic [DW-1:0] exp_data[$];
  int            exp_addr[$];
  bit            exp_last[$];
  int            base_m, wr_m;
  int            total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output/read-address monitor, sampled mid-low-phase
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (buf_rd_en) begin
        if (exp_addr.size() == 0) chk("rd_unexp", buf_rd_en, 0);
        else chk("rd_addr", buf_rd_addr, exp_addr.pop_front());
      end
      if (m_valid) begin
        if (exp_data.size() == 0) chk("mv_unexp", m_valid, 0);
        else begin
          chk("m_data", m_data, exp_data.pop_front());
          chk("m_last", m_last, exp_last.pop_front());
        end
      end
      if (m_last) chk("last_done", done, 1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic write_word(input logic [DW-1:0] d);
    bit rdy;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = d;
    #1;
    rdy = (held.size() < DEPTH);
    chk("s_ready", s_ready, rdy);
    chk("wr_en", buf_wr_en, rdy);
    if (rdy) begin
      chk("wr_addr", buf_wr_addr, wr_m);
      held.push_back(d);
      wr_m = (wr_m + 1) % DEPTH;
    end
  endtask

  task automatic end_writes();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic expect_tile(input int len, input int rep);
    int r;
    r = (rep == 0) ? 1 : rep;
    for (int p = 0; p < r; p++)
      for (int i = 0; i < len; i++) begin
        exp_data.push_back(held[i]);
        exp_addr.push_back((base_m + i) % DEPTH);
        exp_last.push_back((p == r - 1) && (i == len - 1));
      end
  endtask

  task automatic start_tile(input int len, input int rep);
    @(negedge clk);
    start      = 1'b1;
    tile_len   = LW'(len);
    repeat_cnt = RW'(rep);
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: m_ready=1, 1: alternate 1/0, 2: random
  task automatic run_stream(input int len, input int mode, input bit wr_on_done,
                            output int first_v, output int last_v, output int nv);
    int n;
    bit seen;
    bit rdy;
    n = 0; seen = 0; rdy = 0; nv = 0;
    first_v = -1; last_v = -1;
    while (!seen && n < 2000) begin
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (n % 2 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      #3;
      if (m_valid) begin
        if (first_v < 0) first_v = n;
        last_v = n;
        nv++;
      end
      if (done) begin
        seen = 1;
        if (wr_on_done) begin
          s_valid = 1'b1;
          s_data  = DW'($urandom);
          #1;
          rdy = (held.size() < DEPTH);
          chk("rel_s_ready", s_ready, rdy);
        end
      end else begin
        n++;
        @(negedge clk);
      end
    end
    chk("done_seen", seen, 1);
    for (int i = 0; i < len; i++) void'(held.pop_front());
    base_m = (base_m + len) % DEPTH;
    if (wr_on_done && rdy) begin
      held.push_back(s_data);
      wr_m = (wr_m + 1) % DEPTH;
    end
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = 1'b1;
    #1;
    chk("post_busy", busy, 0);
    chk("post_done", done, 0);
    chk("post_level", level, held.size());
    chk("exp_left", exp_data.size(), 0);
  endtask

  initial begin
    int fv, lv, nv, k, len, rep;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    buf_rd_data = '0;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; start = 1'b0;
    tile_len = '0; repeat_cnt = '0; m_ready = 1'b1;
    total = 0; bad = 0; base_m = 0; wr_m = 0;

    // 1: reset values
    @(negedge clk); #1;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_level", level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_wr_en", buf_wr_en, 0);
    chk("rst_rd_en", buf_rd_en, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1b: reset in the middle of streaming
    for (int i = 0; i < 4; i++) write_word(DW'($urandom));
    end_writes();
    expect_tile(4, 5);
    start_tile(4, 5);
    k = 0;
    while (!m_valid && k < 20) begin
      @(negedge clk); #3;
      k++;
    end
    chk("mid_valid_seen", m_valid, 1);
    @(negedge clk);
    rst_n = 1'b0;
    held.delete(); exp_data.delete(); exp_addr.delete(); exp_last.delete();
    base_m = 0; wr_m = 0;
    #3;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    chk("mid_rst_done2", done, 0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("mid_rel_level", level, 0);
    chk("mid_rel_s_ready", s_ready, 1);
    chk("mid_rel_done", done, 0);

    // 2: fill all 16 slots, 17th word held off
    for (int i = 0; i < 17; i++) write_word(DW'(i));
    end_writes();
    #1;
    chk("full_level", level, 16);
    chk("full_s_ready", s_ready, 0);

    // 3: len=4 rep=3, back-to-back
    expect_tile(4, 3);
    start_tile(4, 3);
    run_stream(4, 0, 0, fv, lv, nv);
    chk("t3_latency", fv, 2);
    chk("t3_span", lv - fv, 11);
    chk("t3_count", nv, 12);
    chk("t3_level", level, 12);

    // 4: m_ready alternating
    expect_tile(4, 3);
    start_tile(4, 3);
    run_stream(4, 1, 0, fv, lv, nv);
    chk("t4_span", lv - fv, 22);
    chk("t4_count", nv, 12);

    // 5: move base to 14, then a wrapping tile with a write during RELEASE
    expect_tile(6, 1);
    start_tile(6, 1);
    run_stream(6, 0, 0, fv, lv, nv);
    for (int i = 0; i < 4; i++) write_word(DW'($urandom));
    end_writes();
    #1;
    chk("t5_level_pre", level, 6);
    expect_tile(6, 1);
    start_tile(6, 1);
    run_stream(6, 0, 1, fv, lv, nv);
    chk("t5_level", level, 1);

    // 6: rejected start, zero-length tile, wait for fill
    start_tile(17, 1);
    #1;
    chk("err_pulse", err, 1);
    chk("err_busy", busy, 0);
    @(negedge clk); #1;
    chk("err_clear", err, 0);
    chk("err_idle", busy, 0);
    start_tile(0, 2);
    #1;
    chk("zero_done", done, 1);
    @(negedge clk); #1;
    chk("zero_done_clear", done, 0);
    chk("zero_idle", busy, 0);
    chk("zero_level", level, 1);
    for (int i = 0; i < 4; i++) write_word(DW'($urandom));
    end_writes();
    start_tile(8, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("fill_busy", busy, 1);
      chk("fill_no_valid", m_valid, 0);
    end
    for (int i = 0; i < 3; i++) write_word(DW'($urandom));
    end_writes();
    expect_tile(8, 1);
    run_stream(8, 0, 0, fv, lv, nv);
    chk("fill_count", nv, 8);

    // Randomized tiles
    for (int t = 0; t < 8; t++) begin
      if (held.size() < DEPTH) begin
        k = $urandom_range(1, DEPTH - held.size());
        for (int i = 0; i < k; i++) write_word(DW'($urandom));
        end_writes();
      end
      len = $urandom_range(1, held.size());
      rep = $urandom_range(0, 3);
      expect_tile(len, rep);
      start_tile(len, rep);
      run_stream(len, 2, 0, fv, lv, nv);
      chk("rnd_count", nv, len * ((rep == 0) ? 1 : rep));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
